// File: rtl/cmd_dispatcher_if.sv
// cmd_dispatcher_if: groups the command, IO-module and sender handshakes of
// the command dispatcher. master = dispatcher side, slave = environment side.
// Ports: cmd_* (decoder -> dispatcher), io_* (dispatcher <-> IO module),
//        tx_* (dispatcher -> UART sender), busy (status).
interface cmd_dispatcher_if #(
  parameter int INSTRUCTION_SIZE = 3,
  parameter int REGISTER_SIZE    = 5,
  parameter int AUXILIAR_SIZE    = 44,
  parameter int RESULT_BYTES     = 1
);
  localparam int CMD_WIDTH = INSTRUCTION_SIZE + REGISTER_SIZE + AUXILIAR_SIZE;

  logic [CMD_WIDTH-1:0]        cmd_data;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [INSTRUCTION_SIZE-1:0] io_instr;
  logic [REGISTER_SIZE-1:0]    io_register;
  logic [AUXILIAR_SIZE-1:0]    io_auxiliar;
  logic                        io_valid;
  logic                        io_busy;
  logic                        io_done;
  logic [8*RESULT_BYTES-1:0]   io_result;
  logic [7:0]                  tx_byte;
  logic                        tx_valid;
  logic                        tx_ready;
  logic                        busy;

  modport master (
    input  cmd_data, cmd_valid, io_busy, io_done, io_result, tx_ready,
    output cmd_ready, io_instr, io_register, io_auxiliar, io_valid,
           tx_byte, tx_valid, busy
  );

  modport slave (
    output cmd_data, cmd_valid, io_busy, io_done, io_result, tx_ready,
    input  cmd_ready, io_instr, io_register, io_auxiliar, io_valid,
           tx_byte, tx_valid, busy
  );
endinterface

// File: rtl/cmd_dispatcher.sv
// Purpose: issue one decoded command to the IO module, then stream an ASCII response.
// Latency: io_valid 1 cycle after accept; first tx byte 2 cycles after io_done (or after a BSY accept).
// Backpressure: cmd_ready only in IDLE; tx_byte held stable while tx_valid & !tx_ready.
//
// Ports: clk, rst (synchronous, active-high); bus (cmd_dispatcher_if.master)
//   carrying cmd_data/valid/ready, io_instr/register/auxiliar/valid/busy/done/
//   result, tx_byte/valid/ready and busy.
// Optional build macro CMD_TIMEOUT_EN: enables the ISSUE/WAIT watchdog that
// answers "TO" after TIMEOUT_CYCLES cycles without io_done.
module cmd_dispatcher #(
  parameter int INSTRUCTION_SIZE = 3,
  parameter int REGISTER_SIZE    = 5,
  parameter int AUXILIAR_SIZE    = 44,
  parameter int RESULT_BYTES     = 1,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input logic             clk,
  input logic             rst,
  cmd_dispatcher_if.master bus
);
  localparam int CMD_WIDTH = INSTRUCTION_SIZE + REGISTER_SIZE + AUXILIAR_SIZE;
  localparam int BUF_DEPTH = (2*RESULT_BYTES+2 > 5) ? 2*RESULT_BYTES+2 : 5;
  localparam int IW        = $clog2(BUF_DEPTH);
  localparam int LW        = $clog2(BUF_DEPTH+1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOAD, S_SEND} state_e;
  typedef enum logic [2:0] {R_OK, R_HEX, R_BIT, R_BSY, R_TO} rsp_e;

  state_e                      state_q;
  rsp_e                        class_q;
  logic                        cmd_ready_q, busy_q, io_valid_q, tx_valid_q;
  logic [7:0]                  tx_byte_q;
  logic [INSTRUCTION_SIZE-1:0] io_instr_q;
  logic [REGISTER_SIZE-1:0]    io_register_q;
  logic [AUXILIAR_SIZE-1:0]    io_auxiliar_q;
  logic [8*RESULT_BYTES-1:0]   result_q;
  logic [7:0]                  buf_q [BUF_DEPTH];
  logic [LW-1:0]               len_q;
  logic [IW-1:0]               idx_q;
`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0]               cnt_q;
`endif

  logic [7:0]    resp_buf_d [BUF_DEPTH];
  logic [LW-1:0] resp_len_d;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic rsp_e class_of(input logic [INSTRUCTION_SIZE-1:0] op);
    if (!op[INSTRUCTION_SIZE-1] || op == INSTRUCTION_SIZE'(3'b111)) return R_OK;
    else if (op == INSTRUCTION_SIZE'(3'b110))                       return R_HEX;
    else                                                             return R_BIT;
  endfunction

  // Response image built from the captured class/result; copied into the
  // buffer during LOAD so SEND only has to walk an index.
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) resp_buf_d[i] = 8'h00;
    resp_len_d = '0;
    case (class_q)
      R_HEX: begin
        for (int i = 0; i < 2*RESULT_BYTES; i++)
          resp_buf_d[i] = hex_digit(result_q[8*RESULT_BYTES-1-4*i -: 4]);
        resp_buf_d[2*RESULT_BYTES]   = 8'h0D;
        resp_buf_d[2*RESULT_BYTES+1] = 8'h0A;
        resp_len_d = LW'(2*RESULT_BYTES+2);
      end
      R_BIT: begin
        resp_buf_d[0] = 8'h20;
        resp_buf_d[1] = {7'b0011000, result_q[0]};
        resp_buf_d[2] = 8'h0D;
        resp_buf_d[3] = 8'h0A;
        resp_len_d = LW'(4);
      end
      R_BSY: begin
        resp_buf_d[0] = 8'h42;
        resp_buf_d[1] = 8'h53;
        resp_buf_d[2] = 8'h59;
        resp_buf_d[3] = 8'h0D;
        resp_buf_d[4] = 8'h0A;
        resp_len_d = LW'(5);
      end
      R_TO: begin
        resp_buf_d[0] = 8'h54;
        resp_buf_d[1] = 8'h4F;
        resp_buf_d[2] = 8'h0D;
        resp_buf_d[3] = 8'h0A;
        resp_len_d = LW'(4);
      end
      default: begin
        resp_buf_d[0] = 8'h4F;
        resp_buf_d[1] = 8'h4B;
        resp_buf_d[2] = 8'h0D;
        resp_buf_d[3] = 8'h0A;
        resp_len_d = LW'(4);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      class_q       <= R_OK;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      io_valid_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      io_instr_q    <= '0;
      io_register_q <= '0;
      io_auxiliar_q <= '0;
      result_q      <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= 8'h00;
`ifdef CMD_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      io_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.io_busy) begin
              // IO module occupied: answer BSY without touching the io_* fields.
              class_q <= R_BSY;
              state_q <= S_LOAD;
            end else begin
              io_instr_q    <= bus.cmd_data[CMD_WIDTH-1 -: INSTRUCTION_SIZE];
              io_register_q <= bus.cmd_data[AUXILIAR_SIZE+REGISTER_SIZE-1 -: REGISTER_SIZE];
              io_auxiliar_q <= bus.cmd_data[AUXILIAR_SIZE-1:0];
              io_valid_q    <= 1'b1;
              state_q       <= S_ISSUE;
`ifdef CMD_TIMEOUT_EN
              cnt_q         <= '0;
`endif
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          state_q <= S_WAIT;
          // io_done takes priority over a coincident watchdog expiry.
          if (bus.io_done) begin
            result_q <= bus.io_result;
            class_q  <= class_of(io_instr_q);
            state_q  <= S_LOAD;
          end
`ifdef CMD_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
            class_q <= R_TO;
            state_q <= S_LOAD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        S_LOAD: begin
          for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= resp_buf_d[i];
          len_q      <= resp_len_d;
          idx_q      <= '0;
          tx_byte_q  <= resp_buf_d[0];
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            if (LW'(idx_q) == len_q - LW'(1)) begin
              tx_valid_q  <= 1'b0;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              idx_q     <= idx_q + IW'(1);
              tx_byte_q <= buf_q[idx_q + IW'(1)];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.io_valid    = io_valid_q;
  assign bus.io_instr    = io_instr_q;
  assign bus.io_register = io_register_q;
  assign bus.io_auxiliar = io_auxiliar_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.tx_valid    = tx_valid_q;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// Testbench for cmd_dispatcher: RESULT_BYTES=2, TIMEOUT_CYCLES=16.
// Responses are predicted from the opcode/result rules; timing from the
// documented cycle offsets relative to command acceptance.
module tb_cmd_dispatcher;
  localparam int RB     = 2;
  localparam int TO_CYC = 16;
`ifdef CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_dispatcher_if #(.INSTRUCTION_SIZE(3), .REGISTER_SIZE(5), .AUXILIAR_SIZE(44),
                      .RESULT_BYTES(RB)) bif ();

  cmd_dispatcher #(.INSTRUCTION_SIZE(3), .REGISTER_SIZE(5), .AUXILIAR_SIZE(44),
                   .RESULT_BYTES(RB), .TIMEOUT_CYCLES(TO_CYC))
    dut (.clk(clk), .rst(rst), .bus(bif.master));

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [2:0]  last_instr = '0;
  logic [4:0]  last_reg   = '0;
  logic [43:0] last_aux   = '0;
  string hexchars = "0123456789ABCDEF";

  // Reference response text for one transaction.
  task automatic build_expected(input logic [2:0] op, input bit bsy, input bit tmo,
                                input logic [15:0] r);
    exp_q.delete();
    if (bsy) exp_q = '{8'h42, 8'h53, 8'h59, 8'h0D, 8'h0A};
    else if (tmo) exp_q = '{8'h54, 8'h4F, 8'h0D, 8'h0A};
    else if (op == 3'b110) begin
      for (int i = 2*RB-1; i >= 0; i--) exp_q.push_back(8'(hexchars[(r >> (4*i)) & 16'hF]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end else if (op == 3'b100 || op == 3'b101)
      exp_q = '{8'h20, 8'h30 + {7'd0, r[0]}, 8'h0D, 8'h0A};
    else exp_q = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bif.cmd_valid = 1'b0; bif.io_busy = 1'b0; bif.io_done = 1'b0; bif.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_instr = '0; last_reg = '0; last_aux = '0;
  endtask

  // One command from acceptance to response completion.
  // k: cycle (1 = cycle after accept) carrying io_done, 0 = never.
  // ready_mode: 0 always ready, 1 random, 2 toggle. abort_after>0: rst after that many bytes.
  task automatic do_txn(input string name, input logic [2:0] op, input bit busy_in,
                        input int k, input logic [15:0] res, input int ready_mode,
                        input bit stray, input int abort_after);
    logic [7:0] got_q[$];
    logic [4:0]  rg  = 5'($urandom);
    logic [43:0] aux = {12'($urandom), $urandom};
    bit tmo = TO_EN && !busy_in && (k == 0 || k > TO_CYC);
    int first_exp = busy_in ? 2 : (tmo ? TO_CYC + 2 : k + 2);
    int first_got = -1, ioval_cnt = 0, ioval_cyc = -1, c = 1;
    bit prev_stall = 1'b0, aborted = 1'b0, ready;
    logic [7:0] prev_byte = '0;
    build_expected(op, busy_in, tmo, res);
    checks++;
    if (bif.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL %s cmd_ready_before got=%b exp=1", name, bif.cmd_ready);
    end
    bif.cmd_data = {op, rg, aux}; bif.cmd_valid = 1'b1; bif.io_busy = busy_in;
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0; bif.io_busy = 1'b0;
    forever begin
      if (bif.io_valid === 1'b1) begin ioval_cnt++; ioval_cyc = c; end
      if (bif.tx_valid === 1'b1 && first_got < 0) first_got = c;
      if (c == 1) begin
        checks++;
        if (bif.busy !== 1'b1) begin failures++; $display("FAIL %s busy got=%b exp=1", name, bif.busy); end
      end
      if (prev_stall) begin
        checks++;
        if (bif.tx_valid !== 1'b1 || bif.tx_byte !== prev_byte) begin
          failures++;
          $display("FAIL %s stall_hold cyc%0d got=%b/%h exp=1/%h", name, c, bif.tx_valid, bif.tx_byte, prev_byte);
        end
      end
      if (bif.cmd_ready === 1'b1) break;
      if (c > 400) begin
        checks++; failures++;
        $display("FAIL %s timeout_bound got=no_completion exp=completion", name);
        break;
      end
      ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom) : 1'(c % 2);
      bif.tx_ready = ready;
      bif.io_done = (c == k) || (stray && c >= first_exp - 1);
      bif.io_result = (c == k) ? res : 16'($urandom);
      if (bif.tx_valid === 1'b1 && ready) got_q.push_back(bif.tx_byte);
      prev_stall = (bif.tx_valid === 1'b1) && !ready;
      prev_byte = bif.tx_byte;
      @(posedge clk); #1; c++;
      if (abort_after > 0 && got_q.size() == abort_after) begin
        bif.tx_ready = 1'b0; bif.io_done = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        last_instr = '0; last_reg = '0; last_aux = '0;
        aborted = 1'b1;
        break;
      end
    end
    bif.io_done = 1'b0; bif.tx_ready = 1'b0;
    checks++;
    if (ioval_cnt != (busy_in ? 0 : 1) || (!busy_in && ioval_cyc != 1)) begin
      failures++;
      $display("FAIL %s io_valid got=%0d@%0d exp=%0d@1", name, ioval_cnt, ioval_cyc, busy_in ? 0 : 1);
    end
    checks++;
    if (first_got != first_exp) begin
      failures++; $display("FAIL %s first_tx_cycle got=%0d exp=%0d", name, first_got, first_exp);
    end
    if (!aborted) begin
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++; $display("FAIL %s length got=%0d exp=%0d", name, got_q.size(), exp_q.size());
      end
      if (ready_mode == 0) begin
        checks++;
        if (c != first_exp + exp_q.size()) begin
          failures++; $display("FAIL %s ready_again_cycle got=%0d exp=%0d", name, c, first_exp + exp_q.size());
        end
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL %s byte%0d got=%h exp=%h", name, i, got_q[i], exp_q[i]);
      end
    end
    if (!busy_in && !aborted) begin last_instr = op; last_reg = rg; last_aux = aux; end
    checks++;
    if ({bif.io_instr, bif.io_register, bif.io_auxiliar} !== {last_instr, last_reg, last_aux}) begin
      failures++;
      $display("FAIL %s io_fields got=%h/%h/%h exp=%h/%h/%h", name, bif.io_instr, bif.io_register,
               bif.io_auxiliar, last_instr, last_reg, last_aux);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bif.cmd_ready, bif.busy, bif.io_valid, bif.tx_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b%b%b%b exp=1000", bif.cmd_ready, bif.busy, bif.io_valid, bif.tx_valid);
    end
    checks++;
    if ({bif.tx_byte, bif.io_instr, bif.io_register, bif.io_auxiliar} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bif.tx_byte, bif.io_instr, bif.io_register, bif.io_auxiliar);
    end
  endtask

  task automatic test_ok_response();
    do_txn("ok_001", 3'b001, 1'b0, 4, 16'h1234, 0, 1'b0, 0);
    do_txn("ok_111", 3'b111, 1'b0, 2, 16'hFFFF, 0, 1'b0, 0);
  endtask

  task automatic test_hex_response();
    do_txn("hex_a5f0", 3'b110, 1'b0, 2, 16'hA5F0, 0, 1'b0, 0);
    do_txn("hex_09fa", 3'b110, 1'b0, 3, 16'h09FA, 1, 1'b0, 0);
  endtask

  task automatic test_bit_response();
    do_txn("bit_101_1", 3'b101, 1'b0, 1, 16'h0001, 0, 1'b0, 0);
    do_txn("bit_100_0", 3'b100, 1'b0, 3, 16'hFFFE, 0, 1'b0, 0);
  endtask

  task automatic test_busy_response();
    do_txn("busy", 3'b001, 1'b1, 0, 16'h0000, 0, 1'b0, 0);
  endtask

  task automatic test_wait_or_timeout();
    if (TO_EN) begin
      do_txn("timeout", 3'b110, 1'b0, 0, 16'h0000, 0, 1'b0, 0);
      do_txn("done_final_count", 3'b110, 1'b0, TO_CYC, 16'h3C7E, 0, 1'b0, 0);
      do_txn("done_too_late", 3'b001, 1'b0, TO_CYC + 1, 16'h0000, 0, 1'b0, 0);
    end else begin
      do_txn("long_wait", 3'b001, 1'b0, 40, 16'h0000, 0, 1'b0, 0);
    end
  endtask

  task automatic test_stray_done();
    bif.io_done = 1'b1; bif.io_result = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1 bif.io_done = 1'b0;
    checks++;
    if ({bif.busy, bif.cmd_ready, bif.tx_valid} !== 3'b010) begin
      failures++;
      $display("FAIL stray_idle got=%b%b%b exp=010", bif.busy, bif.cmd_ready, bif.tx_valid);
    end
    do_txn("stray_send", 3'b110, 1'b0, 2, 16'h51E7, 1, 1'b1, 0);
  endtask

  task automatic test_stall_and_reset();
    do_txn("stall_abort", 3'b110, 1'b0, 3, 16'hC3D2, 2, 1'b0, 2);
    checks++;
    if ({bif.tx_valid, bif.busy, bif.cmd_ready} !== 3'b001 || bif.tx_byte !== 8'h00) begin
      failures++;
      $display("FAIL after_abort got=%b%b%b/%h exp=001/00", bif.tx_valid, bif.busy, bif.cmd_ready, bif.tx_byte);
    end
    bif.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bif.tx_valid !== 1'b0) begin
        failures++; $display("FAIL abandoned_tx cyc%0d got=%b exp=0", i, bif.tx_valid);
      end
      @(posedge clk); #1;
    end
    bif.tx_ready = 1'b0;
    do_txn("fresh_after_rst", 3'b110, 1'b0, 2, 16'h7E81, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 16; n++) begin
      do_txn("random", 3'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(1, 6),
             16'($urandom), $urandom_range(0, 1), 1'($urandom), 0);
    end
  endtask

  initial begin
    bif.cmd_data = '0; bif.cmd_valid = 1'b0; bif.io_busy = 1'b0;
    bif.io_done = 1'b0; bif.io_result = '0; bif.tx_ready = 1'b0;
    test_reset();
    test_ok_response();
    test_hex_response();
    test_bit_response();
    test_busy_response();
    test_wait_or_timeout();
    test_stray_done();
    test_stall_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Parametrised command dispatcher that sits between the command decoder and the IO module / UART sender. It accepts one decoded command word per transaction and issues it to the IO module with a request/done handshake. It then builds a variable-length ASCII response (OK, bit value, multi-byte hex result, busy or timeout) in an internal buffer and streams it byte-by-byte to the sender over a valid/ready handshake.

## Interface
- INSTRUCTION_SIZE, 3, opcode width (command MSBs)
- REGISTER_SIZE, 5, register-select field width
- AUXILIAR_SIZE, 44, auxiliary field width (command LSBs)
- CMD_WIDTH, INSTRUCTION_SIZE+REGISTER_SIZE+AUXILIAR_SIZE, command word width
- RESULT_BYTES, 1, IO result width in bytes; legal range 1..4
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; must be ≥2
- Reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_data  in  CMD_WIDTH  {opcode, register, auxiliar}, MSB first
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; transfer on cmd_valid&cmd_ready
- io_instr  out  INSTRUCTION_SIZE  latched opcode
- io_register  out  REGISTER_SIZE  latched register field
- io_auxiliar  out  AUXILIAR_SIZE  latched auxiliary field
- io_valid  out  1  one-cycle request pulse
- io_busy  in  1  IO module busy
- io_done  in  1  one-cycle completion pulse; io_result valid in the same cycle
- io_result  in  8*RESULT_BYTES  read data
- tx_byte  out  8  response byte
- tx_valid  out  1  tx_byte valid; held until tx_ready
- tx_ready  in  1  sender accepts byte
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, LOAD, SEND.
- IDLE: cmd_ready=1. On transfer with io_busy=0, latch the fields and go to ISSUE. On transfer with io_busy=1, latch nothing and go to LOAD with response BSY.
- ISSUE: io_valid=1 for exactly this cycle, then WAIT. io_done is sampled in ISSUE and WAIT.
- WAIT: on io_done, capture io_result, select the response class from the opcode and go to LOAD.
- Response classes:
  - opcode MSB=0 or opcode=3'b111 → OK: 0x4F 0x4B 0x0D 0x0A.
  - 3'b110 → HEX: 2*RESULT_BYTES ASCII digits, most significant nibble first, then 0x0D 0x0A. Digit = 0x30+n for n≤9, 0x37+n for n≥10 (uppercase).
  - 3'b100/3'b101 → BIT: 0x20, 0x30+io_result[0], 0x0D, 0x0A.
  - BSY: 0x42 0x53 0x59 0x0D 0x0A.
  - TO: 0x54 0x4F 0x0D 0x0A.
- LOAD: fill the buffer (depth max(5, 2*RESULT_BYTES+2)) and the length register; clear the byte index; go to SEND.
- SEND: tx_byte=buffer[index], tx_valid=1. On tx_ready, increment the index. Acceptance of the last byte → IDLE.
- The io_* field outputs hold their values until the next issued command.

## Timing
- Reset values: state IDLE, cmd_ready=1 (after reset deasserts), busy=0, io_valid=0, tx_valid=0, tx_byte=0, io_instr/io_register/io_auxiliar=0, buffer index and length 0.
- Command accepted at edge N:
  - io_valid is high in cycle N+1.
  - io_done at edge N+k moves the block to LOAD in N+k+1.
  - The first tx_valid is in N+k+2.
- A response of L bytes with tx_ready tied high takes L cycles in SEND. cmd_ready reasserts the cycle after the last byte is accepted.
- BSY path: first tx_valid is 2 cycles after acceptance.
- tx_byte must be stable while tx_valid=1 and tx_ready=0.
- io_done outside ISSUE/WAIT is ignored.
- rst mid-operation: all state returns to reset values at the next edge. Any partial response is abandoned; no further bytes are sent.

## Configuration
- CMD_TIMEOUT_EN defined: a counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT. When it reaches TIMEOUT_CYCLES-1 with no io_done, the block goes to LOAD with response TO. If io_done and the timeout occur in the same cycle, io_done wins.
- CMD_TIMEOUT_EN undefined: no counter is instantiated; WAIT holds indefinitely until io_done.

## Test plan
- Opcode 3'b001, io_done 3 cycles after io_valid, tx_ready=1 → io_valid for one cycle; bytes 0x4F 0x4B 0x0D 0x0A on consecutive cycles; cmd_ready high afterwards.
- RESULT_BYTES=2, opcode 3'b110, io_result=16'hA5F0 → 0x41 0x35 0x46 0x30 0x0D 0x0A.
- Opcode 3'b101, io_result[0]=1 → 0x20 0x31 0x0D 0x0A. Repeat with io_result[0]=0 → 0x20 0x30 0x0D 0x0A.
- Command presented while io_busy=1 → io_valid stays low; response 0x42 0x53 0x59 0x0D 0x0A.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, io_done never asserted → 0x54 0x4F 0x0D 0x0A starts 18 cycles after acceptance. With io_done on the final count instead → normal response.
- tx_ready toggling 1/0 during a HEX response, then rst asserted after the 2nd byte → bytes are held stable while stalled; after reset, tx_valid=0 and busy=0, and a fresh command completes normally.
